// File: rtl/ip_tx_pkg.sv
// Shared types and constants for the IP transmit ARP resolution controller.
package ip_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARP_REQ  = 3'd1,
    ST_ARP_WAIT = 3'd2,
    ST_FWD      = 3'd3,
    ST_DROP     = 3'd4
  } ip_tx_state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [2:0]  FLAGS_DF      = 3'b010;

endpackage

// File: rtl/ip_arp_cache_entry.sv
// Single-entry IP->MAC cache: combinational lookup, write on resolve,
// targeted invalidate on failed resolve, and a global clear that wins over a write.
module ip_arp_cache_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_ip,
  output logic        hit,
  output logic [47:0] lookup_mac,
  input  logic        wr_en,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic        inval_en,
  input  logic [31:0] inval_ip,
  input  logic        clear
);

  logic        entry_valid;
  logic [31:0] entry_ip;
  logic [47:0] entry_mac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= 1'b0;
    end else if (clear) begin
      entry_valid <= 1'b0;
    end else if (wr_en) begin
      entry_valid <= 1'b1;
    end else if (inval_en && (inval_ip == entry_ip)) begin
      entry_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_ip  <= wr_ip;
      entry_mac <= wr_mac;
    end
  end

  assign hit        = entry_valid && (entry_ip == lookup_ip);
  assign lookup_mac = entry_mac;

endmodule

// File: rtl/ip_tx_arp_ctrl.sv
// Resolves the destination MAC of outgoing IP packets through a one-entry cache
// and an external ARP engine, then forwards or drops the header and payload.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1; a raised valid holds, with its data stable, until that transfer.
module ip_tx_arp_ctrl
  import ip_tx_pkg::*;
#(
  parameter int          DATA_WIDTH  = 64,
  parameter int          KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter logic [15:0] ETH_TYPE    = ETH_TYPE_IPV4,
  parameter int          ARP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_ip_hdr_valid,
  output logic                  s_ip_hdr_ready,
  input  logic [5:0]            s_ip_dscp,
  input  logic [1:0]            s_ip_ecn,
  input  logic [15:0]           s_ip_length,
  input  logic [7:0]            s_ip_ttl,
  input  logic [7:0]            s_ip_protocol,
  input  logic [31:0]           s_ip_source_ip,
  input  logic [31:0]           s_ip_dest_ip,
  input  logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
  input  logic                  s_ip_payload_axis_tvalid,
  output logic                  s_ip_payload_axis_tready,
  input  logic                  s_ip_payload_axis_tlast,
  input  logic                  s_ip_payload_axis_tuser,
  output logic                  m_ip_hdr_valid,
  input  logic                  m_ip_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [5:0]            m_ip_dscp,
  output logic [1:0]            m_ip_ecn,
  output logic [15:0]           m_ip_length,
  output logic [15:0]           m_ip_identification,
  output logic [2:0]            m_ip_flags,
  output logic [12:0]           m_ip_fragment_offset,
  output logic [7:0]            m_ip_ttl,
  output logic [7:0]            m_ip_protocol,
  output logic [31:0]           m_ip_source_ip,
  output logic [31:0]           m_ip_dest_ip,
  output logic [DATA_WIDTH-1:0] m_ip_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_ip_payload_axis_tkeep,
  output logic                  m_ip_payload_axis_tvalid,
  input  logic                  m_ip_payload_axis_tready,
  output logic                  m_ip_payload_axis_tlast,
  output logic                  m_ip_payload_axis_tuser,
  output logic                  arp_request_valid,
  input  logic                  arp_request_ready,
  output logic [31:0]           arp_request_ip,
  input  logic                  arp_response_valid,
  output logic                  arp_response_ready,
  input  logic                  arp_response_error,
  input  logic [47:0]           arp_response_mac,
  input  logic [47:0]           local_mac,
  input  logic                  cache_clear,
  output logic                  busy,
  output logic                  err_arp_failed,
  output logic                  err_arp_timeout,
  output logic [31:0]           drop_count,
  output ip_tx_state_t          dbg_state
);

  ip_tx_state_t state, state_next;
  logic [15:0]  wait_cnt;
  logic [15:0]  id_cnt;
  logic         cache_hit;
  logic [47:0]  cache_mac;
  logic         hdr_load;
  logic         timeout_hit;
  logic         resp_ok;
  logic         resp_err;
  logic         hdr_done;
  logic         pass_en;
  logic         fwd_last;
  logic         drop_last;

  ip_arp_cache_entry u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_ip  (s_ip_dest_ip),
    .hit        (cache_hit),
    .lookup_mac (cache_mac),
    .wr_en      (resp_ok),
    .wr_ip      (s_ip_dest_ip),
    .wr_mac     (arp_response_mac),
    .inval_en   (resp_err),
    .inval_ip   (s_ip_dest_ip),
    .clear      (cache_clear)
  );

  assign timeout_hit = (wait_cnt == 16'(ARP_TIMEOUT - 1));
  assign resp_ok     = (state == ST_ARP_WAIT) && arp_response_valid && !arp_response_error;
  assign resp_err    = (state == ST_ARP_WAIT) && arp_response_valid && arp_response_error;

  // The last beat is held back until the header has left, so IDLE never
  // starts with a header still pending downstream.
  assign hdr_done  = !m_ip_hdr_valid || m_ip_hdr_ready;
  assign pass_en   = !s_ip_payload_axis_tlast || hdr_done;
  assign fwd_last  = (state == ST_FWD) && s_ip_payload_axis_tvalid && m_ip_payload_axis_tready
                     && s_ip_payload_axis_tlast && hdr_done;
  assign drop_last = (state == ST_DROP) && s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast;

  always_comb begin
    state_next         = state;
    s_ip_hdr_ready     = 1'b0;
    arp_request_valid  = 1'b0;
    arp_response_ready = 1'b0;
    err_arp_failed     = 1'b0;
    err_arp_timeout    = 1'b0;
    hdr_load           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_ip_hdr_valid) begin
          if (cache_hit) begin
            s_ip_hdr_ready = 1'b1;
            hdr_load       = 1'b1;
            state_next     = ST_FWD;
          end else begin
            state_next = ST_ARP_REQ;
          end
        end
      end
      ST_ARP_REQ: begin
        arp_request_valid = 1'b1;
        if (arp_request_ready) state_next = ST_ARP_WAIT;
      end
      ST_ARP_WAIT: begin
        arp_response_ready = 1'b1;
        if (arp_response_valid) begin
          s_ip_hdr_ready = 1'b1;
          if (arp_response_error) begin
            err_arp_failed = 1'b1;
            state_next     = ST_DROP;
          end else begin
            hdr_load   = 1'b1;
            state_next = ST_FWD;
          end
        end else if (timeout_hit) begin
          err_arp_timeout = 1'b1;
          s_ip_hdr_ready  = 1'b1;
          state_next      = ST_DROP;
        end
      end
      ST_FWD:  if (fwd_last)  state_next = ST_IDLE;
      ST_DROP: if (drop_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      m_ip_hdr_valid <= 1'b0;
      id_cnt         <= '0;
      drop_count     <= '0;
    end else begin
      state <= state_next;
      if (state == ST_ARP_REQ)       wait_cnt <= '0;
      else if (state == ST_ARP_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (hdr_load)            m_ip_hdr_valid <= 1'b1;
      else if (m_ip_hdr_ready) m_ip_hdr_valid <= 1'b0;
      if (m_ip_hdr_valid && m_ip_hdr_ready) id_cnt <= id_cnt + 16'd1;
      if (drop_last && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_load) begin
      m_eth_dest_mac      <= (state == ST_IDLE) ? cache_mac : arp_response_mac;
      m_ip_dscp           <= s_ip_dscp;
      m_ip_ecn            <= s_ip_ecn;
      m_ip_length         <= s_ip_length;
      m_ip_ttl            <= s_ip_ttl;
      m_ip_protocol       <= s_ip_protocol;
      m_ip_source_ip      <= s_ip_source_ip;
      m_ip_dest_ip        <= s_ip_dest_ip;
      m_ip_identification <= id_cnt;
    end
  end

  assign arp_request_ip       = s_ip_dest_ip;
  assign m_eth_src_mac        = local_mac;
  assign m_eth_type           = ETH_TYPE;
  assign m_ip_flags           = FLAGS_DF;
  assign m_ip_fragment_offset = '0;

  assign m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
  assign m_ip_payload_axis_tkeep  = s_ip_payload_axis_tkeep;
  assign m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
  assign m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser;
  assign m_ip_payload_axis_tvalid = (state == ST_FWD) && s_ip_payload_axis_tvalid && pass_en;
  assign s_ip_payload_axis_tready = ((state == ST_FWD) && m_ip_payload_axis_tready && pass_en)
                                    || (state == ST_DROP);

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ip_tx_arp_ctrl.sv
// Directed bench for ip_tx_arp_ctrl: a table of packet scenarios plus
// hand-written backpressure, cache-clear and reset-in-flight sequences.
module tb_ip_tx_arp_ctrl;
  import ip_tx_pkg::*;

  localparam int          DW        = 256;
  localparam int          KW        = DW / 8;
  localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_00AA;
  localparam logic [47:0] MAC_A     = 48'h0200_0000_0002;
  localparam logic [47:0] MAC_B     = 48'h0A0B_0C0D_0E0F;
  localparam int          M_HIT = 0, M_OK = 1, M_ERR = 2, M_NONE = 3;

  logic          clk, rst_n;
  logic          s_ip_hdr_valid, s_ip_hdr_ready;
  logic [5:0]    s_ip_dscp;
  logic [1:0]    s_ip_ecn;
  logic [15:0]   s_ip_length;
  logic [7:0]    s_ip_ttl, s_ip_protocol;
  logic [31:0]   s_ip_source_ip, s_ip_dest_ip;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic          m_ip_hdr_valid, m_ip_hdr_ready;
  logic [47:0]   m_eth_dest_mac, m_eth_src_mac;
  logic [15:0]   m_eth_type, m_ip_length, m_ip_identification;
  logic [5:0]    m_ip_dscp;
  logic [1:0]    m_ip_ecn;
  logic [2:0]    m_ip_flags;
  logic [12:0]   m_ip_fragment_offset;
  logic [7:0]    m_ip_ttl, m_ip_protocol;
  logic [31:0]   m_ip_source_ip, m_ip_dest_ip;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic          arp_request_valid, arp_request_ready;
  logic [31:0]   arp_request_ip;
  logic          arp_response_valid, arp_response_ready, arp_response_error;
  logic [47:0]   arp_response_mac;
  logic          cache_clear, busy, err_arp_failed, err_arp_timeout;
  logic [31:0]   drop_count;
  ip_tx_state_t  dbg_state;

  ip_tx_arp_ctrl #(.DATA_WIDTH(DW), .ARP_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
    .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
    .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
    .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
    .m_ip_identification(m_ip_identification), .m_ip_flags(m_ip_flags),
    .m_ip_fragment_offset(m_ip_fragment_offset), .m_ip_ttl(m_ip_ttl),
    .m_ip_protocol(m_ip_protocol), .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
    .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
    .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip), .arp_response_valid(arp_response_valid),
    .arp_response_ready(arp_response_ready), .arp_response_error(arp_response_error),
    .arp_response_mac(arp_response_mac), .local_mac(LOCAL_MAC), .cache_clear(cache_clear),
    .busy(busy), .err_arp_failed(err_arp_failed), .err_arp_timeout(err_arp_timeout),
    .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            arp_req_cnt = 0, hdr_cnt = 0, fail_cnt = 0, to_cnt = 0;
  int            req_cyc = 0, to_cyc = 0;
  logic [47:0]   last_mac;
  logic [15:0]   last_id;
  logic [31:0]   cur_ip;
  bit            bp_mode = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s wait bound expired", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (arp_request_valid && arp_request_ready) begin
        arp_req_cnt++;
        req_cyc = cyc + 1;
        chk("arp_request_ip", arp_request_ip, cur_ip);
      end
      if (err_arp_failed) fail_cnt++;
      if (err_arp_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (m_ip_hdr_valid && m_ip_hdr_ready) begin
        hdr_cnt++;
        last_mac = m_eth_dest_mac;
        last_id  = m_ip_identification;
        chk("hdr_dest_ip", m_ip_dest_ip, cur_ip);
        chk("hdr_src_mac", m_eth_src_mac, LOCAL_MAC);
        chk("hdr_eth_type", m_eth_type, 16'h0800);
        chk("hdr_flags_frag", {m_ip_flags, m_ip_fragment_offset}, {3'b010, 13'd0});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) expired("unexpected_out_beat");
        else begin
          chk("beat_data", m_tdata, exp_q.pop_front());
          chk("beat_last", m_tlast, exp_last_q.pop_front());
        end
      end
    end
  end

  // Downstream payload ready: steady 1, or alternating 1010 when bp_mode is set.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = bp_mode ? ~m_tready : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pkt(input logic [31:0] ip, input int nbeats, input bit fwd);
    int w;
    logic [DW-1:0] d;
    @(posedge clk); #1;
    s_ip_hdr_valid = 1'b1;
    s_ip_dest_ip   = ip;
    s_ip_source_ip = 32'hC0A8_0001;
    s_ip_length    = 16'(20 + nbeats * KW);
    s_ip_ttl       = 8'd64;
    s_ip_protocol  = 8'd17;
    s_ip_dscp      = 6'd10;
    s_ip_ecn       = 2'd1;
    w = 0;
    @(negedge clk);
    while (!s_ip_hdr_ready && w < 100) begin @(negedge clk); w++; end
    if (!s_ip_hdr_ready) expired("hdr_accept");
    @(posedge clk); #1;
    s_ip_hdr_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      s_tdata  = d;
      s_tkeep  = '1;
      s_tlast  = (b == nbeats - 1);
      s_tvalid = 1'b1;
      if (fwd) begin
        exp_q.push_back(d);
        exp_last_q.push_back(b == nbeats - 1);
      end
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 100) begin @(negedge clk); w++; end
      if (!s_tready) expired("payload_accept");
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic arp_respond(input int mode, input logic [47:0] mac, input int delay);
    int w = 0;
    @(negedge clk);
    while (!(arp_request_valid && arp_request_ready) && w < 100) begin @(negedge clk); w++; end
    if (!(arp_request_valid && arp_request_ready)) begin
      expired("arp_request");
      return;
    end
    if (mode == M_NONE) return;
    @(posedge clk); #1;
    repeat (delay) begin @(posedge clk); #1; end
    arp_response_valid = 1'b1;
    arp_response_mac   = mac;
    arp_response_error = (mode == M_ERR);
    w = 0;
    @(negedge clk);
    while (!arp_response_ready && w < 100) begin @(negedge clk); w++; end
    if (!arp_response_ready) expired("arp_response");
    @(posedge clk); #1;
    arp_response_valid = 1'b0;
    arp_response_error = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ip;
    int          beats;
    int          mode;
    logic [47:0] mac;
    int          delay;
    int          exp_arp;
    bit          exp_fwd;
    logic [15:0] exp_id;
    logic [31:0] exp_drop;
    int          exp_fail;
    int          exp_to;
  } vec_t;

  function automatic vec_t mk(logic [31:0] ip, int beats, int mode, logic [47:0] mac, int delay,
                              int ea, bit ef, logic [15:0] eid, logic [31:0] ed, int efl, int eto);
    vec_t v;
    v.ip = ip; v.beats = beats; v.mode = mode; v.mac = mac; v.delay = delay;
    v.exp_arp = ea; v.exp_fwd = ef; v.exp_id = eid; v.exp_drop = ed;
    v.exp_fail = efl; v.exp_to = eto;
    return v;
  endfunction

  task automatic run_pkt(input vec_t v, input string tag);
    int a0, h0, f0, t0;
    a0 = arp_req_cnt; h0 = hdr_cnt; f0 = fail_cnt; t0 = to_cnt;
    cur_ip = v.ip;
    fork
      send_pkt(v.ip, v.beats, v.exp_fwd);
      begin
        if (v.mode != M_HIT) arp_respond(v.mode, v.mac, v.delay);
      end
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_arp_requests"}, 32'(arp_req_cnt - a0), 32'(v.exp_arp));
    chk({tag, "_hdr_out"}, 32'(hdr_cnt - h0), v.exp_fwd ? 32'd1 : 32'd0);
    if (v.exp_fwd) begin
      chk({tag, "_dest_mac"}, last_mac, v.mac);
      chk({tag, "_ident"}, last_id, v.exp_id);
    end
    chk({tag, "_drop_count"}, drop_count, v.exp_drop);
    chk({tag, "_err_failed"}, 32'(fail_cnt - f0), 32'(v.exp_fail));
    chk({tag, "_err_timeout"}, 32'(to_cnt - t0), 32'(v.exp_to));
    if (v.exp_to != 0) chk({tag, "_timeout_cycle"}, 32'(to_cyc - req_cyc), 32'd15);
    chk({tag, "_state_idle"}, {dbg_state, busy}, {ST_IDLE, 1'b0});
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_ctl_outs"},
        {busy, m_ip_hdr_valid, s_ip_hdr_ready, arp_request_valid, arp_response_ready,
         err_arp_failed, err_arp_timeout, m_tvalid, s_tready}, 9'd0);
    chk({tag, "_drop_count"}, drop_count, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(32'h0A00_0002, 2, M_OK,   MAC_A, 3,  1, 1, 16'd0, 32'd0, 0, 0);
    vecs[1] = mk(32'h0A00_0002, 1, M_HIT,  MAC_A, 0,  0, 1, 16'd1, 32'd0, 0, 0);
    vecs[2] = mk(32'h0A00_0003, 3, M_ERR,  MAC_B, 2,  1, 0, 16'd0, 32'd1, 1, 0);
    vecs[3] = mk(32'h0A00_0002, 2, M_HIT,  MAC_A, 0,  0, 1, 16'd2, 32'd1, 0, 0);
    vecs[4] = mk(32'h0A00_0005, 2, M_NONE, MAC_B, 0,  1, 0, 16'd0, 32'd2, 0, 1);
    vecs[5] = mk(32'h0A00_0007, 2, M_OK,   MAC_B, 15, 1, 1, 16'd3, 32'd2, 0, 0);
    vecs[6] = mk(32'h0A00_0007, 1, M_HIT,  MAC_B, 0,  0, 1, 16'd4, 32'd2, 0, 0);
    vecs[7] = mk(32'h0A00_0002, 1, M_OK,   MAC_A, 0,  1, 1, 16'd5, 32'd2, 0, 0);

    rst_n = 1'b0;
    s_ip_hdr_valid = 1'b0; s_ip_dest_ip = '0; s_ip_source_ip = '0; s_ip_length = '0;
    s_ip_ttl = '0; s_ip_protocol = '0; s_ip_dscp = '0; s_ip_ecn = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_ip_hdr_ready = 1'b1; arp_request_ready = 1'b1;
    arp_response_valid = 1'b0; arp_response_error = 1'b0; arp_response_mac = '0;
    cache_clear = 1'b0; cur_ip = '0;
    #1;
    chk_all_low("reset");
    #21 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

    // 4-beat hit with downstream ready alternating every cycle
    bp_mode = 1;
    run_pkt(mk(32'h0A00_0002, 4, M_HIT, MAC_A, 0, 0, 1, 16'd6, 32'd2, 0, 0), "backpressure");
    bp_mode = 0;
    @(posedge clk); #1;

    // cache_clear between two packets to the same, previously resolved IP
    cache_clear = 1'b1;
    @(posedge clk); #1;
    cache_clear = 1'b0;
    run_pkt(mk(32'h0A00_0002, 1, M_OK, MAC_A, 1, 1, 1, 16'd7, 32'd2, 0, 0), "after_clear");

    // reset while waiting on ARP, then a fresh request for the formerly cached IP
    begin
      int w = 0;
      cur_ip = 32'h0A00_0009;
      s_ip_dest_ip   = 32'h0A00_0009;
      s_ip_hdr_valid = 1'b1;
      @(negedge clk);
      while (dbg_state != ST_ARP_WAIT && w < 20) begin @(negedge clk); w++; end
      if (dbg_state != ST_ARP_WAIT) expired("reach_arp_wait");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_all_low("rst_in_wait");
      s_ip_hdr_valid = 1'b0;
      #14 rst_n = 1'b1;
    end
    run_pkt(mk(32'h0A00_0002, 2, M_OK, MAC_A, 2, 1, 1, 16'd0, 32'd0, 0, 0), "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d", total);
    $fatal(1, "global time limit");
  end

endmodule
